// File: rtl/dram_read_arbiter.sv
// Two-port round-robin read arbiter/sequencer in front of a single-port dram_bank.
// Optional open-row-hit priority is enabled by defining DRAM_ARB_ROW_HIT_PRIORITY_EN.
module dram_read_arbiter #(
    parameter int ROW_W   = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [ROW_W-1:0]  row0,
    input  logic [ROW_W-1:0]  row1,
    output logic [1:0]        gnt,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ROW_W-1:0]  bank_row,
    output logic              bank_valid,
    input  logic [DATA_W-1:0] bank_data,
    input  logic              bank_out_valid
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic              id_r, id_s;
    logic [7:0]        cnt_r, cnt_s;
    logic              last_r, last_s;
    logic              win_s;
    logic              timeout_s;
    logic [1:0]        gnt_r, gnt_s;
    logic [1:0]        rsp_valid_r, rsp_valid_s;
    logic [DATA_W-1:0] rsp_data_r, rsp_data_s;
    logic              rsp_err_r, rsp_err_s;
    logic [ROW_W-1:0]  bank_row_r, bank_row_s;
    logic              bank_valid_r, bank_valid_s;

`ifdef DRAM_ARB_ROW_HIT_PRIORITY_EN
    logic [ROW_W-1:0]  open_row_r;
    logic              open_vld_r;
    logic              hit0_s, hit1_s;

    // Open-row comparison for both requesters
    always_comb begin
        hit0_s = open_vld_r && (row0 == open_row_r);
        hit1_s = open_vld_r && (row1 == open_row_r);
    end

    // Open-row tracker: set by every issue, invalidated when the bank times out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_row_r <= '0;
            open_vld_r <= 1'b0;
        end else if (state_r == ISSUE) begin
            open_row_r <= bank_row_r;
            open_vld_r <= 1'b1;
        end else if (timeout_s) begin
            open_vld_r <= 1'b0;
        end else begin
            open_row_r <= open_row_r;
            open_vld_r <= open_vld_r;
        end
    end
`endif

    // Winner selection: lone requester wins, ties go to the one not served last
    always_comb begin
        win_s = 1'b0;
        if (req == 2'b01) begin
            win_s = 1'b0;
        end else if (req == 2'b10) begin
            win_s = 1'b1;
        end else if (req == 2'b11) begin
`ifdef DRAM_ARB_ROW_HIT_PRIORITY_EN
            if (hit0_s && !hit1_s) begin
                win_s = 1'b0;
            end else if (hit1_s && !hit0_s) begin
                win_s = 1'b1;
            end else begin
                win_s = ~last_r;
            end
`else
            win_s = ~last_r;
`endif
        end else begin
            win_s = 1'b0;
        end
    end

    // Timeout fires only when no bank data arrives in the same cycle
    always_comb begin
        timeout_s = (state_r == WAIT) && !bank_out_valid && (cnt_r == TIMEOUT_C);
    end

    // Next-state and next-output computation; outputs are registered below
    always_comb begin
        state_s      = state_r;
        id_s         = id_r;
        cnt_s        = cnt_r;
        last_s       = last_r;
        gnt_s        = 2'b00;
        rsp_valid_s  = 2'b00;
        rsp_data_s   = rsp_data_r;
        rsp_err_s    = rsp_err_r;
        bank_row_s   = bank_row_r;
        bank_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req != 2'b00) begin
                    state_s      = ISSUE;
                    id_s         = win_s;
                    gnt_s        = win_s ? 2'b10 : 2'b01;
                    bank_valid_s = 1'b1;
                    bank_row_s   = win_s ? row1 : row0;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                cnt_s   = 8'd0;
                state_s = WAIT;
            end
            WAIT: begin
                if (bank_out_valid) begin
                    rsp_data_s  = bank_data;
                    rsp_err_s   = 1'b0;
                    rsp_valid_s = id_r ? 2'b10 : 2'b01;
                    state_s     = RESP;
                end else if (timeout_s) begin
                    rsp_data_s  = '0;
                    rsp_err_s   = 1'b1;
                    rsp_valid_s = id_r ? 2'b10 : 2'b01;
                    state_s     = RESP;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            RESP: begin
                last_s  = id_r;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered-output update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            id_r         <= 1'b0;
            cnt_r        <= 8'd0;
            last_r       <= 1'b1;
            gnt_r        <= 2'b00;
            rsp_valid_r  <= 2'b00;
            rsp_data_r   <= '0;
            rsp_err_r    <= 1'b0;
            bank_row_r   <= '0;
            bank_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            id_r         <= id_s;
            cnt_r        <= cnt_s;
            last_r       <= last_s;
            gnt_r        <= gnt_s;
            rsp_valid_r  <= rsp_valid_s;
            rsp_data_r   <= rsp_data_s;
            rsp_err_r    <= rsp_err_s;
            bank_row_r   <= bank_row_s;
            bank_valid_r <= bank_valid_s;
        end
    end

    assign gnt        = gnt_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_data   = rsp_data_r;
    assign rsp_err    = rsp_err_r;
    assign bank_row   = bank_row_r;
    assign bank_valid = bank_valid_r;

endmodule

// File: tb/tb_dram_read_arbiter.sv
// Randomized self-checking bench for dram_read_arbiter with a transaction-level
// arbitration/latency model and a behavioural bank responder.
module tb_dram_read_arbiter;

    localparam int T = 31;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [3:0]  row0, row1;
    logic [1:0]  gnt, rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [3:0]  bank_row;
    logic        bank_valid;
    logic [31:0] bank_data;
    logic        bank_out_valid;

    int          n_tests = 0;
    int          n_fail  = 0;

    // bank responder configuration (written by main, read by responder)
    int          bank_delay = 1;
    logic [31:0] bank_word  = 32'd0;
    int          stray_req_cnt = 0;
    int          r_stray_done = 0;
    int          r_d;
    logic [31:0] r_w;

    // reference model state: who was served last, open row
    int          m_last = 1;
    logic [3:0]  m_open_row = 4'd0;
    bit          m_open_vld = 1'b0;

    dram_read_arbiter #(.ROW_W(4), .DATA_W(32), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .req(req), .row0(row0), .row1(row1),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .bank_row(bank_row), .bank_valid(bank_valid),
        .bank_data(bank_data), .bank_out_valid(bank_out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_win(input logic [1:0] r, input logic [3:0] a, input logic [3:0] b);
        if (r == 2'b01) return 1'b0;
        if (r == 2'b10) return 1'b1;
`ifdef DRAM_ARB_ROW_HIT_PRIORITY_EN
        if (m_open_vld && ((a == m_open_row) != (b == m_open_row)))
            return (b == m_open_row);
`endif
        return (m_last == 0) ? 1'b1 : 1'b0;
    endfunction

    // Behavioural bank: answers an issue after bank_delay cycles (0 = never)
    initial begin
        bank_out_valid = 1'b0;
        bank_data      = 32'd0;
        forever begin
            @(negedge clk);
            if (r_stray_done != stray_req_cnt) begin
                r_stray_done   = stray_req_cnt;
                bank_data      = 32'hFF;
                bank_out_valid = 1'b1;
                @(negedge clk);
                bank_out_valid = 1'b0;
            end else if (bank_valid) begin
                r_d = bank_delay;
                r_w = bank_word;
                if (r_d > 0) begin
                    repeat (r_d) @(negedge clk);
                    bank_data      = r_w;
                    bank_out_valid = 1'b1;
                    @(negedge clk);
                    bank_out_valid = 1'b0;
                end
            end
        end
    end

    // One full transaction; called at a negedge with the DUT idle
    task automatic do_txn(input logic [1:0] r, input logic [3:0] a, input logic [3:0] b,
                          input int delay, input logic [31:0] word, input bit hold);
        logic       w;
        logic [3:0] erow;
        int         lat;
        int         exp_lat;
        bit         tmo;
        bit         seen;
        w    = exp_win(r, a, b);
        erow = w ? b : a;
        req  = r; row0 = a; row1 = b;
        bank_delay = delay;
        bank_word  = word;
        @(negedge clk);
        check("gnt", 32'(gnt), w ? 32'd2 : 32'd1);
        check("bank_valid", 32'(bank_valid), 32'd1);
        check("bank_row", 32'(bank_row), 32'(erow));
        if (!hold) begin
            req  = 2'($urandom_range(0, 3));
            row0 = 4'($urandom);
            row1 = 4'($urandom);
        end
        tmo     = (delay == 0) || (delay > T + 1);
        exp_lat = tmo ? T + 2 : delay + 1;
        lat = 0;
        seen = 1'b0;
        for (int i = 1; i <= T + 10; i++) begin
            @(negedge clk);
            if (i == 1) check("gnt_pulse", 32'(gnt), 32'd0);
            if (rsp_valid != 2'b00) begin
                lat  = i;
                seen = 1'b1;
                break;
            end
        end
        check("rsp_seen", 32'(seen), 32'd1);
        check("rsp_valid", 32'(rsp_valid), w ? 32'd2 : 32'd1);
        check("rsp_lat", 32'(lat), 32'(exp_lat));
        check("rsp_err", 32'(rsp_err), 32'(tmo));
        check("rsp_data", rsp_data, tmo ? 32'd0 : word);
        m_last     = int'(w);
        m_open_row = erow;
        m_open_vld = !tmo;
        @(negedge clk);
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
        if (!hold) req = 2'b00;
    endtask

    initial begin
        int          cnt;
        logic [31:0] held;
        rst  = 1'b1;
        req  = 2'b00;
        row0 = 4'd0;
        row1 = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_bank_valid", 32'(bank_valid), 32'd0);
        check("rst_bank_row", 32'(bank_row), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // contention: grants alternate starting with requester 0
        for (int i = 0; i < 4; i++)
            do_txn(2'b11, 4'd0, 4'd15, $urandom_range(1, 4), $urandom, 1'b1);
        req = 2'b00;
        @(negedge clk);

        do_txn(2'b01, 4'd0, 4'd7, 2, 32'h1234, 1'b0);
        do_txn(2'b10, 4'd2, 4'd9, 0, $urandom, 1'b0);
        do_txn(2'b01, 4'd4, 4'd5, T + 1, $urandom, 1'b0);
        do_txn(2'b10, 4'd4, 4'd5, T + 2, $urandom, 1'b0);

        // open-row hit versus round-robin
        do_txn(2'b10, 4'd3, 4'd10, 1, $urandom, 1'b0);
        do_txn(2'b11, 4'd3, 4'd10, 1, $urandom, 1'b0);

        // stray bank valid while idle
        held = rsp_data;
        stray_req_cnt++;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid != 2'b00 || gnt != 2'b00) cnt++;
        end
        check("stray_no_rsp", 32'(cnt), 32'd0);
        check("stray_data_held", rsp_data, held);

        // reset in WAIT, bank answers afterwards
        req  = 2'b01; row0 = 4'd5;
        bank_delay = 5;
        bank_word  = $urandom;
        @(negedge clk);
        check("rw_gnt", 32'(gnt), 32'd1);
        req = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rw_outputs", {rsp_data[15:0], 7'd0, rsp_err, bank_valid, bank_row, gnt, rsp_valid}, 32'd0);
        check("rw_rsp_data", rsp_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_last = 1;
        m_open_vld = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) cnt++;
        end
        check("rw_no_rsp", 32'(cnt), 32'd0);
        check("rw_data_zero", rsp_data, 32'd0);
        do_txn(2'b11, 4'd1, 4'd2, 3, $urandom, 1'b0);

        // randomized traffic
        for (int i = 0; i < 30; i++)
            do_txn(2'($urandom_range(1, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6)), $urandom, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
